// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the two-port sram bus arbiter: FSM states, size codes and owner codes.
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbAddr = 2'd1,
    ArbData = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } size_e;

  typedef enum logic {
    OwnInst = 1'b0,
    OwnData = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared sram-like bus around the arbiter.
interface sram_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [1:0]        d_size;
  logic [STRB_W-1:0] d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [STRB_W-1:0] bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  // Requesters plus bus bridge side.
  modport master (
    output i_req, i_addr,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/sram_bus_arbiter_arb_grant_2.sv
// Combinational two-way pick between fetch and data requests.
module sram_bus_arbiter_arb_grant_2
  import sram_bus_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   prio_mode,
  input  owner_e last_win,
  output owner_e grant
);

  always_comb begin
    grant = OwnInst;
    if (d_req && !i_req) begin
      grant = OwnData;
    end else if (d_req && i_req) begin
      // Round-robin tie goes to whoever lost the previous tie.
      grant = (prio_mode || last_win == OwnInst) ? OwnData : OwnInst;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like bus between fetch and load/store ports, one transaction outstanding.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DATA_PRIO = 1
) (
  input logic               clk,
  input logic               reset,
  sram_bus_arbiter_if.slave arb
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam logic        PrioMode = (DATA_PRIO != 0);

  arb_state_e        state_q;
  owner_e            owner_q;
  owner_e            last_win_q;
  owner_e            grant;
  logic              bus_req_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  sram_bus_arbiter_arb_grant_2 u_grant (
    .i_req    (arb.i_req),
    .d_req    (arb.d_req),
    .prio_mode(PrioMode),
    .last_win (last_win_q),
    .grant    (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ArbIdle;
      owner_q    <= OwnInst;
      last_win_q <= OwnInst;
      bus_req_q  <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (arb.i_req || arb.d_req) begin
            state_q   <= ArbAddr;
            bus_req_q <= 1'b1;
            owner_q   <= grant;
            if (!PrioMode && arb.i_req && arb.d_req) last_win_q <= grant;
            if (grant == OwnData) begin
              wr_q    <= arb.d_wr;
              size_q  <= arb.d_size;
              wstrb_q <= arb.d_wstrb;
              addr_q  <= arb.d_addr;
              wdata_q <= arb.d_wdata;
            end else begin
              wr_q    <= 1'b0;
              size_q  <= SzWord;
              wstrb_q <= '0;
              addr_q  <= arb.i_addr;
              wdata_q <= '0;
            end
          end
        end
        ArbAddr: begin
          if (arb.bus_addr_ok) begin
            state_q   <= ArbData;
            bus_req_q <= 1'b0;
          end
        end
        ArbData: begin
          if (arb.bus_data_ok) state_q <= ArbIdle;
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign arb.bus_req   = bus_req_q;
  assign arb.bus_wr    = wr_q;
  assign arb.bus_size  = size_q;
  assign arb.bus_wstrb = wstrb_q;
  assign arb.bus_addr  = addr_q;
  assign arb.bus_wdata = wdata_q;

  // Handshake pulses are steered straight from the bus to the owner; a simultaneous
  // data_ok while still in ADDR is dropped because only the DATA state looks at it.
  logic addr_hit;
  logic data_hit;
  assign addr_hit = !reset && (state_q == ArbAddr) && arb.bus_addr_ok;
  assign data_hit = !reset && (state_q == ArbData) && arb.bus_data_ok;

  assign arb.i_addr_ok = addr_hit && (owner_q == OwnInst);
  assign arb.d_addr_ok = addr_hit && (owner_q == OwnData);
  assign arb.i_data_ok = data_hit && (owner_q == OwnInst);
  assign arb.d_data_ok = data_hit && (owner_q == OwnData);
  assign arb.i_rdata   = arb.i_data_ok ? arb.bus_rdata : '0;
  assign arb.d_rdata   = arb.d_data_ok ? arb.bus_rdata : '0;

endmodule
